// File: rtl/i2c_cmd_sequencer.sv
// Command-level sequencer for the Wishbone I2C master core. Runs the core's init writes,
// then turns each register read/write command into TXR/CR writes plus SR polling.
module i2c_cmd_sequencer #(
  parameter logic [15:0] PRESCALE      = 16'd99,
  parameter logic [15:0] TIMEOUT_POLLS = 16'd4095
) (
  input  logic       clk,
  input  logic       axi_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam logic [3:0] INIT0   = 4'd0;
  localparam logic [3:0] INIT1   = 4'd1;
  localparam logic [3:0] INIT2   = 4'd2;
  localparam logic [3:0] IDLE    = 4'd3;
  localparam logic [3:0] TXR     = 4'd4;
  localparam logic [3:0] CR      = 4'd5;
  localparam logic [3:0] POLL    = 4'd6;
  localparam logic [3:0] RDRX    = 4'd7;
  localparam logic [3:0] STOPERR = 4'd8;
  localparam logic [3:0] RESP    = 4'd9;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;

  logic [3:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        stop_q, stop_d;       // polling the STOP issued after a NACK
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  regaddr_q, regaddr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        acc_req, acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat, txr_byte, cr_byte;
  logic [15:0] cnt_inc;

  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Byte and control values for the current step of the transaction
  always_comb begin
    txr_byte = 8'h00;
    cr_byte  = 8'h00;
    unique case (step_q)
      2'd0: begin txr_byte = {dev_q, 1'b0}; cr_byte = 8'h90; end
      2'd1: begin txr_byte = regaddr_q;     cr_byte = 8'h10; end
      2'd2: begin
        txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte  = rd_q ? 8'h90 : 8'h50;
      end
      default: begin txr_byte = 8'h00; cr_byte = 8'h68; end
    endcase
  end

  // Wishbone access each bus state wants to perform
  always_comb begin
    acc_req = 1'b1;
    acc_we  = 1'b1;
    acc_adr = ADR_PRERLO;
    acc_dat = 8'h00;
    unique case (state_q)
      INIT0:   acc_dat = PRESCALE[7:0];
      INIT1:   begin acc_adr = ADR_PRERHI; acc_dat = PRESCALE[15:8]; end
      INIT2:   begin acc_adr = ADR_CTR;    acc_dat = 8'h80; end
      TXR:     begin acc_adr = ADR_TXR;    acc_dat = txr_byte; end
      CR:      begin acc_adr = ADR_CR;     acc_dat = cr_byte; end
      POLL:    begin acc_adr = ADR_CR;     acc_we  = 1'b0; end
      RDRX:    begin acc_adr = ADR_TXR;    acc_we  = 1'b0; end
      STOPERR: begin acc_adr = ADR_CR;     acc_dat = 8'h40; end
      default: acc_req = 1'b0;
    endcase
  end

  // Next-state: bus handshake, status decisions and command/response handshakes
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    stop_d    = stop_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rd_d      = rd_q;
    dev_d     = dev_q;
    regaddr_d = regaddr_q;
    wdata_d   = wdata_q;

    if (stb_q) begin
      if (wb_ack_i) begin
        stb_d = 1'b0;
        unique case (state_q)
          INIT0:   state_d = INIT1;
          INIT1:   state_d = INIT2;
          INIT2:   state_d = IDLE;
          TXR:     state_d = CR;
          CR:      begin state_d = POLL; cnt_d = 16'd0; end
          STOPERR: begin state_d = POLL; cnt_d = 16'd0; stop_d = 1'b1; end
          RDRX:    begin state_d = RESP; rdata_d = wb_dat_i; err_d = 2'b00; end
          POLL: begin
            if (wb_dat_i[1]) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= TIMEOUT_POLLS) begin
                state_d = RESP;
                err_d   = 2'b11;
              end
            end else if (stop_q) begin
              state_d = RESP;
              err_d   = 2'b01;
            end else if (wb_dat_i[5]) begin
              state_d = RESP;
              err_d   = 2'b10;
            end else if (step_q == 2'd3) begin
              // RxACK is our own NACK on the final read byte
              state_d = RDRX;
            end else if (wb_dat_i[7]) begin
              state_d = STOPERR;
            end else if (!rd_q && step_q == 2'd2) begin
              state_d = RESP;
              err_d   = 2'b00;
            end else begin
              step_d  = step_q + 2'd1;
              // Final read step has no TXR byte, only the read command
              state_d = (rd_q && step_q == 2'd2) ? CR : TXR;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end else if (acc_req) begin
      stb_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end

    if (state_q == IDLE && cmd_valid) begin
      state_d   = TXR;
      step_d    = 2'd0;
      stop_d    = 1'b0;
      rdata_d   = 8'h00;
      err_d     = 2'b00;
      rd_d      = cmd_rd;
      dev_d     = cmd_dev;
      regaddr_d = cmd_reg;
      wdata_d   = cmd_wdata;
    end

    if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= INIT0;
      step_q    <= 2'd0;
      stop_q    <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      dat_q     <= 8'h00;
      cnt_q     <= 16'd0;
      rdata_q   <= 8'h00;
      err_q     <= 2'b00;
      rd_q      <= 1'b0;
      dev_q     <= 7'h00;
      regaddr_q <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      stop_q    <= stop_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      dev_q     <= dev_d;
      regaddr_q <= regaddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: register-level model of the I2C core with one slave at 7'h50,
// expected Wishbone writes and responses queued when a command is driven.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       axi_reset_n;
  logic       cmd_valid, cmd_ready, cmd_rd;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack_i;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.PRESCALE(16'd99), .TIMEOUT_POLLS(16'd8)) dut (
    .clk(clk), .axi_reset_n(axi_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  typedef struct { logic we; logic [2:0] adr; logic [7:0] dat; } acc_t;
  typedef struct { logic [1:0] err; logic [7:0] rdata; } rsp_t;
  typedef struct {
    logic rd; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd; logic al;
    logic [1:0] exp_err; logic [7:0] exp_rdata;
  } vec_t;

  localparam logic [6:0] SLAVE = 7'h50;

  acc_t exp_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   sr_reads = 0;
  int   rsp_count = 0;
  bit   al_mode = 1'b0;
  bit   stuck_mode = 1'b0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endfunction

  // Core model: registered ack, TIP busy for 3 SR reads after each CR write
  logic       mdl_ack;
  logic [7:0] mdl_dat, txr, rxr, ptr;
  logic       rxack, al, bus_busy, addressed;
  int         busy_polls, byte_idx;
  logic [7:0] mem [256];

  assign wb_ack_i = mdl_ack;
  assign wb_dat_i = mdl_dat;

  always @(posedge clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      mdl_ack <= 1'b0; mdl_dat <= 8'h00; txr <= 8'h00; rxr <= 8'h00; ptr <= 8'h00;
      rxack <= 1'b0; al <= 1'b0; bus_busy <= 1'b0; addressed <= 1'b0;
      busy_polls <= 0; byte_idx <= 0;
    end else begin
      mdl_ack <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !mdl_ack) begin
        mdl_ack <= 1'b1;
        if (wb_we_o) begin
          if (wb_adr_o == 3'd3) txr <= wb_dat_o;
          if (wb_adr_o == 3'd4) begin
            busy_polls <= 3;
            if (wb_dat_o[7]) begin
              addressed <= (txr[7:1] == SLAVE);
              rxack     <= (txr[7:1] != SLAVE);
              byte_idx  <= 0;
              bus_busy  <= !al_mode;
              al        <= al_mode;
            end else if (wb_dat_o[4]) begin
              rxack <= !addressed;
              if (addressed) begin
                if (byte_idx == 0) ptr <= txr;
                else begin
                  mem[ptr] <= txr;
                  ptr      <= ptr + 8'd1;
                end
              end
              byte_idx <= byte_idx + 1;
            end
            if (wb_dat_o[5]) rxr <= mem[ptr];
            if (wb_dat_o[6]) bus_busy <= 1'b0;
          end
        end else begin
          if (wb_adr_o == 3'd3) mdl_dat <= rxr;
          else if (stuck_mode || busy_polls != 0) mdl_dat <= 8'h02;
          else mdl_dat <= {rxack, 1'b0, al, 5'b00000};
          if (busy_polls != 0) busy_polls <= busy_polls - 1;
        end
      end
    end
  end

  // Scoreboard: compare completed accesses and responses mid-cycle
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (!wb_we_o && wb_adr_o == 3'd4) begin
        sr_reads <= sr_reads + 1;
      end else if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL wb_access: got we=%0b adr=%0d dat=%h, required no access",
                 wb_we_o, wb_adr_o, wb_dat_o);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        check("wb_we", wb_we_o, e.we);
        check("wb_adr", wb_adr_o, e.adr);
        if (e.we) check("wb_dat", wb_dat_o, e.dat);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp: got err=%0d rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_err", rsp_err, r.err);
        check("rsp_rdata", rsp_rdata, r.rdata);
      end
      rsp_count <= rsp_count + 1;
    end
  end

  task automatic push_acc(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    acc_t a;
    a.we = we; a.adr = adr; a.dat = dat;
    exp_q.push_back(a);
  endtask

  // Expected bus writes for a command, derived from the protocol sequence
  task automatic push_expected(input vec_t v);
    rsp_t r;
    r.err = v.exp_err; r.rdata = v.exp_rdata;
    rsp_q.push_back(r);
    push_acc(1'b1, 3'd3, {v.dev, 1'b0});
    push_acc(1'b1, 3'd4, 8'h90);
    if (v.al) return;
    if (v.dev != SLAVE) begin
      push_acc(1'b1, 3'd4, 8'h40);
      return;
    end
    push_acc(1'b1, 3'd3, v.rg);
    push_acc(1'b1, 3'd4, 8'h10);
    if (!v.rd) begin
      push_acc(1'b1, 3'd3, v.wd);
      push_acc(1'b1, 3'd4, 8'h50);
    end else begin
      push_acc(1'b1, 3'd3, {v.dev, 1'b1});
      push_acc(1'b1, 3'd4, 8'h90);
      push_acc(1'b1, 3'd4, 8'h68);
      push_acc(1'b0, 3'd3, 8'h00);
    end
  endtask

  task automatic init_check();
    int ready_at;
    ready_at = -1;
    push_acc(1'b1, 3'd0, 8'h63);
    push_acc(1'b1, 3'd1, 8'h00);
    push_acc(1'b1, 3'd2, 8'h80);
    axi_reset_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (cmd_ready && ready_at < 0) ready_at = c;
    end
    check("init_ready_cycle", ready_at, 9);
    check("init_writes_left", exp_q.size(), 0);
  endtask

  task automatic start_cmd(input vec_t v);
    bit ok;
    @(negedge clk);
    al_mode = v.al;
    cmd_rd = v.rd; cmd_dev = v.dev; cmd_reg = v.rg; cmd_wdata = v.wd;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_count >= target) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++;
      $display("FAIL rsp_wait: got no response in 3000 cycles, required one");
    end
    check("accesses_left", exp_q.size(), 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int target;
    target = rsp_count + 1;
    push_expected(v);
    start_cmd(v);
    wait_rsp(target);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    bit   found;
    int   base, target;

    axi_reset_n = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_dev = 7'h00;
    cmd_reg = 8'h00; cmd_wdata = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wb_cyc", wb_cyc_o, 0);
    check("rst_wb_stb", wb_stb_o, 0);
    check("rst_wb_adr", wb_adr_o, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    init_check();

    vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 2'b00, 8'h00};
    vecs[1] = '{1'b0, 7'h50, 8'h13, 8'h3C, 1'b0, 2'b00, 8'h00};
    vecs[2] = '{1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 2'b00, 8'hA5};
    vecs[3] = '{1'b1, 7'h50, 8'h13, 8'hFF, 1'b0, 2'b00, 8'h3C};
    vecs[4] = '{1'b0, 7'h21, 8'h12, 8'h77, 1'b0, 2'b01, 8'h00};
    vecs[5] = '{1'b1, 7'h21, 8'h05, 8'h00, 1'b0, 2'b01, 8'h00};
    vecs[6] = '{1'b0, 7'h50, 8'h20, 8'h11, 1'b1, 2'b10, 8'h00};
    vecs[7] = '{1'b1, 7'h50, 8'h13, 8'h00, 1'b1, 2'b10, 8'h00};
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i]);
      check("bus_idle_after_cmd", bus_busy, 0);
    end
    check("slave_mem_12", mem[8'h12], 8'hA5);
    check("slave_mem_20_untouched_by_al", (mem[8'h20] === 8'h11) ? 1 : 0, 0);

    // Timeout with the response held off for 5 cycles
    al_mode = 1'b0;
    stuck_mode = 1'b1;
    rsp_ready = 1'b0;
    v = '{1'b0, 7'h50, 8'h30, 8'h99, 1'b0, 2'b11, 8'h00};
    rsp_q.push_back('{2'b11, 8'h00});
    push_acc(1'b1, 3'd3, 8'hA0);
    push_acc(1'b1, 3'd4, 8'h90);
    base = sr_reads;
    target = rsp_count + 1;
    start_cmd(v);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; break; end
    end
    check("timeout_rsp_seen", found, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    check("timeout_sr_reads", sr_reads - base, 8);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rsp", cmd_ready, 1);
    check("valid_after_rsp", rsp_valid, 0);
    stuck_mode = 1'b0;
    check("timeout_rsp_count", rsp_count, target);
    check("timeout_accesses_left", exp_q.size(), 0);

    // Reset while polling during a read
    v = '{1'b1, 7'h50, 8'h13, 8'h00, 1'b0, 2'b00, 8'h3C};
    push_expected(v);
    start_cmd(v);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wb_stb_o && !wb_we_o && wb_adr_o == 3'd4) begin found = 1'b1; break; end
    end
    check("poll_reached", found, 1);
    #2 axi_reset_n = 1'b0;
    #1;
    check("rst_mid_cyc", wb_cyc_o, 0);
    check("rst_mid_stb", wb_stb_o, 0);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    init_check();
    v = '{1'b0, 7'h50, 8'h40, 8'h5A, 1'b0, 2'b00, 8'h00};
    run_cmd(v);
    check("slave_mem_40", mem[8'h40], 8'h5A);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
